// File: rtl/uart_card_bridge.sv
// uart_card_bridge: parses host command frames from the UART byte stream,
// drives the SD-card driver command/data channels, and returns read blocks
// plus a status byte. Stalled driver handshakes are aborted by a timeout.
`timescale 1ns/1ps
module uart_card_bridge #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned BLOCK_LEN = 512,
  parameter int unsigned TIMEOUT   = 5_000_000
) (
  input  logic              CLOCK50,
  input  logic              RESET,
  input  logic              RX_STB,
  input  logic [7:0]        RX_DAT,
  output logic              RX_ACK,
  output logic              TX_STB,
  output logic [7:0]        TX_DAT,
  input  logic              TX_ACK,
  output logic              WR_STB,
  output logic [ADDR_W-1:0] WR_ADDR,
  input  logic              WR_ACK,
  output logic              WD_STB,
  output logic [7:0]        WD_DATA,
  input  logic              WD_ACK,
  output logic              RD_STB,
  output logic [ADDR_W-1:0] RD_ADDR,
  input  logic              RD_ACK,
  input  logic              RES_STB,
  input  logic [7:0]        RES_DATA,
  output logic              RES_ACK,
  output logic              BUSY
);

  localparam int unsigned ADDR_BYTES = ADDR_W / 8;
  localparam int unsigned CNT_MAX    = (BLOCK_LEN > ADDR_BYTES) ? BLOCK_LEN : ADDR_BYTES;
  localparam int unsigned CNT_W      = $clog2(CNT_MAX + 1);
  localparam int unsigned TO_W       = $clog2(TIMEOUT + 1);

  localparam logic [7:0] OP_WRITE  = 8'h57;
  localparam logic [7:0] OP_READ   = 8'h52;
  localparam logic [7:0] OP_PING   = 8'h50;
  localparam logic [7:0] ST_OK     = 8'h00;
  localparam logic [7:0] ST_PING   = 8'hA5;
  localparam logic [7:0] ST_BADOP  = 8'hE1;
  localparam logic [7:0] ST_TMO    = 8'hE2;
  localparam logic [7:0] PAD_BYTE  = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WCMD, S_WDATA, S_DRAIN, S_RCMD, S_RDATA, S_STATUS
  } state_e;

  state_e              state_q, state_d;
  logic                is_wr_q, is_wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic                pad_q, pad_d;
  logic [7:0]          status_q, status_d;
  logic                tx_stb_q, tx_stb_d;
  logic [7:0]          tx_dat_q, tx_dat_d;
  logic                wd_stb_q, wd_stb_d;
  logic [7:0]          wd_data_q, wd_data_d;
  logic                rx_ack_q, rx_ack_d;
  logic                res_ack_q, res_ack_d;
  logic                wr_stb_q, wr_stb_d;
  logic                rd_stb_q, rd_stb_d;
  logic                busy_q, busy_d;

  logic rx_fire, tx_fire, wr_fire, wd_fire, rd_fire, res_fire;
  logic stall, timeout;

  assign rx_fire  = RX_STB && rx_ack_q;
  assign tx_fire  = tx_stb_q && TX_ACK;
  assign wr_fire  = wr_stb_q && WR_ACK;
  assign wd_fire  = wd_stb_q && WD_ACK;
  assign rd_fire  = rd_stb_q && RD_ACK;
  assign res_fire = RES_STB && res_ack_q;

  // Driver-side stall detection; host RX and TX waits are never timed
  always_comb begin
    stall = (wr_stb_q && !WR_ACK) || (wd_stb_q && !WD_ACK) || (rd_stb_q && !RD_ACK) ||
            (state_q == S_RDATA && !tx_stb_q && !RES_STB && !pad_q);
    timeout = stall && (to_cnt_q == TO_W'(TIMEOUT - 1));
  end

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d   = state_q;
    is_wr_d   = is_wr_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    pad_d     = pad_q;
    status_d  = status_q;
    tx_stb_d  = tx_stb_q;
    tx_dat_d  = tx_dat_q;
    wd_stb_d  = wd_stb_q;
    wd_data_d = wd_data_q;
    to_cnt_d  = to_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (rx_fire) begin
          cnt_d = '0;
          case (RX_DAT)
            OP_WRITE: begin state_d = S_ADDR; is_wr_d = 1'b1; end
            OP_READ:  begin state_d = S_ADDR; is_wr_d = 1'b0; end
            OP_PING:  begin state_d = S_STATUS; tx_stb_d = 1'b1; tx_dat_d = ST_PING; end
            default:  begin state_d = S_STATUS; tx_stb_d = 1'b1; tx_dat_d = ST_BADOP; end
          endcase
        end
      end
      S_ADDR: begin
        if (rx_fire) begin
          addr_d = (addr_q << 8) | ADDR_W'(RX_DAT);
          if (cnt_q == CNT_W'(ADDR_BYTES - 1)) begin
            cnt_d   = '0;
            state_d = is_wr_q ? S_WCMD : S_RCMD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_WCMD: begin
        if (wr_fire)      state_d = S_WDATA;
        else if (timeout) state_d = S_DRAIN;
      end
      S_WDATA: begin
        // cnt counts host bytes accepted, so DRAIN knows how many remain
        if (rx_fire) begin
          wd_data_d = RX_DAT;
          wd_stb_d  = 1'b1;
          cnt_d     = cnt_q + 1'b1;
        end else if (wd_fire) begin
          wd_stb_d = 1'b0;
          if (cnt_q == CNT_W'(BLOCK_LEN)) begin
            state_d  = S_STATUS;
            tx_stb_d = 1'b1;
            tx_dat_d = ST_OK;
          end
        end else if (timeout) begin
          wd_stb_d = 1'b0;
          if (cnt_q == CNT_W'(BLOCK_LEN)) begin
            state_d  = S_STATUS;
            tx_stb_d = 1'b1;
            tx_dat_d = ST_TMO;
          end else begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (rx_fire) begin
          if (cnt_q == CNT_W'(BLOCK_LEN - 1)) begin
            state_d  = S_STATUS;
            tx_stb_d = 1'b1;
            tx_dat_d = ST_TMO;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_RCMD: begin
        if (rd_fire) begin
          state_d  = S_RDATA;
          pad_d    = 1'b0;
          status_d = ST_OK;
        end else if (timeout) begin
          state_d  = S_RDATA;
          pad_d    = 1'b1;
          status_d = ST_TMO;
        end
      end
      S_RDATA: begin
        // cnt counts bytes delivered to TX; the block is always full length
        if (tx_fire) begin
          tx_stb_d = 1'b0;
          if (cnt_q == CNT_W'(BLOCK_LEN - 1)) begin
            state_d  = S_STATUS;
            tx_stb_d = 1'b1;
            tx_dat_d = status_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (!tx_stb_q) begin
          if (pad_q) begin
            tx_stb_d = 1'b1;
            tx_dat_d = PAD_BYTE;
          end else if (res_fire) begin
            tx_stb_d = 1'b1;
            tx_dat_d = RES_DATA;
          end else if (timeout) begin
            pad_d    = 1'b1;
            status_d = ST_TMO;
          end
        end
      end
      S_STATUS: begin
        if (tx_fire) begin
          tx_stb_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if ((state_d != state_q) || rx_fire || tx_fire || wr_fire || wd_fire ||
        rd_fire || res_fire || timeout) begin
      to_cnt_d = '0;
    end else if (stall) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end

    rx_ack_d  = (state_d == S_IDLE) || (state_d == S_ADDR) || (state_d == S_DRAIN) ||
                (state_d == S_WDATA && !wd_stb_d);
    res_ack_d = (state_d == S_RDATA) && !tx_stb_d && !pad_d;
    wr_stb_d  = (state_d == S_WCMD);
    rd_stb_d  = (state_d == S_RCMD);
    busy_d    = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge CLOCK50) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      is_wr_q   <= 1'b0;
      addr_q    <= '0;
      cnt_q     <= '0;
      to_cnt_q  <= '0;
      pad_q     <= 1'b0;
      status_q  <= '0;
      tx_stb_q  <= 1'b0;
      tx_dat_q  <= '0;
      wd_stb_q  <= 1'b0;
      wd_data_q <= '0;
      rx_ack_q  <= 1'b1;
      res_ack_q <= 1'b0;
      wr_stb_q  <= 1'b0;
      rd_stb_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_wr_q   <= is_wr_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      to_cnt_q  <= to_cnt_d;
      pad_q     <= pad_d;
      status_q  <= status_d;
      tx_stb_q  <= tx_stb_d;
      tx_dat_q  <= tx_dat_d;
      wd_stb_q  <= wd_stb_d;
      wd_data_q <= wd_data_d;
      rx_ack_q  <= rx_ack_d;
      res_ack_q <= res_ack_d;
      wr_stb_q  <= wr_stb_d;
      rd_stb_q  <= rd_stb_d;
      busy_q    <= busy_d;
    end
  end

  assign RX_ACK  = rx_ack_q;
  assign TX_STB  = tx_stb_q;
  assign TX_DAT  = tx_dat_q;
  assign WR_STB  = wr_stb_q;
  assign WR_ADDR = addr_q;
  assign WD_STB  = wd_stb_q;
  assign WD_DATA = wd_data_q;
  assign RD_STB  = rd_stb_q;
  assign RD_ADDR = addr_q;
  assign RES_ACK = res_ack_q;
  assign BUSY    = busy_q;

endmodule

// File: tb/tb_uart_card_bridge.sv
// Directed bench for uart_card_bridge: ping/bad opcode, block write and read,
// write and read timeouts, and reset in the middle of a write frame.
`timescale 1ns/1ps
module tb_uart_card_bridge;

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned BLOCK_LEN = 4;
  localparam int unsigned TIMEOUT   = 100;

  logic              clk = 1'b0;
  logic              RESET;
  logic              RX_STB, RX_ACK, TX_STB, TX_ACK;
  logic [7:0]        RX_DAT, TX_DAT, WD_DATA, RES_DATA;
  logic              WR_STB, WR_ACK, WD_STB, WD_ACK, RD_STB, RD_ACK;
  logic              RES_STB, RES_ACK, BUSY;
  logic [ADDR_W-1:0] WR_ADDR, RD_ADDR;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  tx_q[$], wd_q[$], res_q[$], exp_q[$], act_q[$], frame_q[$];
  logic [31:0] wr_q[$], rd_q[$];
  bit          tx_bp, res_gaps, wr_en, rd_en, res_x;
  int          wd_allow, stall_run, stall_max;

  always #5 clk = ~clk;

  uart_card_bridge #(.ADDR_W(ADDR_W), .BLOCK_LEN(BLOCK_LEN), .TIMEOUT(TIMEOUT)) dut (
    .CLOCK50(clk), .RESET(RESET),
    .RX_STB(RX_STB), .RX_DAT(RX_DAT), .RX_ACK(RX_ACK),
    .TX_STB(TX_STB), .TX_DAT(TX_DAT), .TX_ACK(TX_ACK),
    .WR_STB(WR_STB), .WR_ADDR(WR_ADDR), .WR_ACK(WR_ACK),
    .WD_STB(WD_STB), .WD_DATA(WD_DATA), .WD_ACK(WD_ACK),
    .RD_STB(RD_STB), .RD_ADDR(RD_ADDR), .RD_ACK(RD_ACK),
    .RES_STB(RES_STB), .RES_DATA(RES_DATA), .RES_ACK(RES_ACK),
    .BUSY(BUSY)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Compare act_q against exp_q: length first, then each byte
  task automatic check_bytes(input string tag);
    check_eq({tag, "_len"}, 32'(act_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
      check_eq($sformatf("%s_%0d", tag, i), 32'(act_q[i]), 32'(exp_q[i]));
  endtask

  task automatic check_tx(input string tag);
    act_q = tx_q;
    check_bytes(tag);
    tx_q.delete();
  endtask

  // Present one host byte and hold it until accepted (bounded)
  task automatic send_rx(input logic [7:0] b, input string tag);
    bit got = 1'b0;
    RX_STB = 1'b1;
    RX_DAT = b;
    for (int n = 0; n < 400 && !got; n++) begin
      @(negedge clk);
      got = RX_ACK;
      @(posedge clk); #1;
    end
    RX_STB = 1'b0;
    check_eq({tag, "_rx_accept"}, 32'(got), 32'd1);
  endtask

  task automatic send_frame(input string tag);
    while (frame_q.size() > 0) send_rx(frame_q.pop_front(), tag);
  endtask

  // Wait for the bridge to return to idle with nothing left on TX
  task automatic wait_idle(input string tag, input int budget);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (!BUSY && !TX_STB) break;
    end
    check_eq({tag, "_idle"}, 32'(BUSY), 32'd0);
    @(posedge clk); #1;
  endtask

  // Downstream driver, TX sink and RES source models
  initial begin
    TX_ACK = 1'b0; WR_ACK = 1'b0; WD_ACK = 1'b0; RD_ACK = 1'b0;
    RES_STB = 1'b0; RES_DATA = 8'h00; res_x = 1'b0;
    forever begin
      @(posedge clk); #1;
      TX_ACK = tx_bp ? 1'($urandom_range(0, 1)) : 1'b1;
      WR_ACK = WR_STB && wr_en;
      RD_ACK = RD_STB && rd_en;
      WD_ACK = WD_STB && (wd_allow > 0);
      if (res_x) begin
        RES_STB = 1'b0;
        if (res_q.size() > 0) void'(res_q.pop_front());
      end
      if (!RES_STB && res_q.size() > 0 && (!res_gaps || $urandom_range(0, 2) == 0)) begin
        RES_STB  = 1'b1;
        RES_DATA = res_q[0];
      end
      @(negedge clk);
      if (TX_STB && TX_ACK) tx_q.push_back(TX_DAT);
      if (WR_STB && WR_ACK) wr_q.push_back(32'(WR_ADDR));
      if (RD_STB && RD_ACK) rd_q.push_back(32'(RD_ADDR));
      if (WD_STB && WD_ACK) begin
        wd_q.push_back(WD_DATA);
        wd_allow--;
      end
      res_x = RES_STB && RES_ACK;
      if (WD_STB && !WD_ACK) stall_run++;
      else stall_run = 0;
      if (stall_run > stall_max) stall_max = stall_run;
    end
  end

  initial begin
    RESET = 1'b1; RX_STB = 1'b0; RX_DAT = 8'h00;
    tx_bp = 1'b0; res_gaps = 1'b0; wr_en = 1'b1; rd_en = 1'b1;
    wd_allow = 1000; stall_run = 0; stall_max = 0;
    repeat (3) @(posedge clk);
    #1;
    RESET = 1'b0;

    // Reset values
    check_eq("rst_busy",    32'(BUSY),    32'd0);
    check_eq("rst_rx_ack",  32'(RX_ACK),  32'd1);
    check_eq("rst_tx_stb",  32'(TX_STB),  32'd0);
    check_eq("rst_tx_dat",  32'(TX_DAT),  32'd0);
    check_eq("rst_wr_stb",  32'(WR_STB),  32'd0);
    check_eq("rst_wd_stb",  32'(WD_STB),  32'd0);
    check_eq("rst_rd_stb",  32'(RD_STB),  32'd0);
    check_eq("rst_res_ack", 32'(RES_ACK), 32'd0);
    check_eq("rst_wr_addr", 32'(WR_ADDR), 32'd0);
    check_eq("rst_wd_data", 32'(WD_DATA), 32'd0);

    // Ping: BUSY and TX_STB rise right after the opcode edge
    send_rx(8'h50, "ping");
    check_eq("ping_busy",   32'(BUSY),   32'd1);
    check_eq("ping_tx_stb", 32'(TX_STB), 32'd1);
    wait_idle("ping", 50);
    exp_q = '{8'hA5};
    check_tx("ping_tx");

    // Bad opcode
    send_rx(8'h13, "bad");
    wait_idle("bad", 50);
    exp_q = '{8'hE1};
    check_tx("bad_tx");

    // Block write
    wr_q.delete(); wd_q.delete();
    frame_q = '{8'h57, 8'h00, 8'h00, 8'h02, 8'h00};
    send_frame("wr");
    check_eq("wr_stb_after_addr", 32'(WR_STB), 32'd1);
    frame_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_frame("wr");
    wait_idle("wr", 100);
    check_eq("wr_cmd_count", 32'(wr_q.size()), 32'd1);
    check_eq("wr_addr", (wr_q.size() > 0) ? wr_q[0] : 32'hDEADBEEF, 32'h0000_0200);
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    act_q = wd_q;
    check_bytes("wr_data");
    exp_q = '{8'h00};
    check_tx("wr_tx");

    // Block read with RES gaps and TX backpressure
    rd_q.delete();
    tx_bp = 1'b1; res_gaps = 1'b1;
    res_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    frame_q = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h08};
    send_frame("rd");
    check_eq("rd_stb_after_addr", 32'(RD_STB), 32'd1);
    wait_idle("rd", 500);
    check_eq("rd_cmd_count", 32'(rd_q.size()), 32'd1);
    check_eq("rd_addr", (rd_q.size() > 0) ? rd_q[0] : 32'hDEADBEEF, 32'h0000_0008);
    exp_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
    check_tx("rd_tx");
    tx_bp = 1'b0; res_gaps = 1'b0;

    // Write timeout: driver stops acking after two data bytes
    wd_q.delete();
    wd_allow = 2; stall_max = 0;
    frame_q = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h10, 8'h01, 8'h02, 8'h03, 8'h04};
    send_frame("wto");
    wait_idle("wto", 500);
    exp_q = '{8'h01, 8'h02};
    act_q = wd_q;
    check_bytes("wto_data");
    check_eq("wto_stall_cycles", 32'(stall_max), 32'(TIMEOUT));
    check_eq("wto_wd_stb", 32'(WD_STB), 32'd0);
    exp_q = '{8'hE2};
    check_tx("wto_tx");
    wd_allow = 1000;

    // Read timeout: driver returns only the first byte
    res_q = '{8'hAA};
    frame_q = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h0C};
    send_frame("rto");
    wait_idle("rto", 1000);
    exp_q = '{8'hAA, 8'hFF, 8'hFF, 8'hFF, 8'hE2};
    check_tx("rto_tx");

    // Reset in the middle of a write data phase
    wd_allow = 0;
    frame_q = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h20, 8'h5A};
    send_frame("mrst");
    repeat (3) @(posedge clk);
    #1;
    check_eq("mrst_pre_wd_stb", 32'(WD_STB), 32'd1);
    check_eq("mrst_pre_busy",   32'(BUSY),   32'd1);
    RESET = 1'b1;
    @(posedge clk); #1;
    RESET = 1'b0;
    check_eq("mrst_wd_stb", 32'(WD_STB), 32'd0);
    check_eq("mrst_wr_stb", 32'(WR_STB), 32'd0);
    check_eq("mrst_rd_stb", 32'(RD_STB), 32'd0);
    check_eq("mrst_tx_stb", 32'(TX_STB), 32'd0);
    check_eq("mrst_busy",   32'(BUSY),   32'd0);
    check_eq("mrst_rx_ack", 32'(RX_ACK), 32'd1);
    wd_allow = 1000;
    repeat (10) @(posedge clk);
    #1;
    check_eq("mrst_no_tx", 32'(tx_q.size()), 32'd0);
    send_rx(8'h50, "mrst_ping");
    wait_idle("mrst_ping", 50);
    exp_q = '{8'hA5};
    check_tx("mrst_ping_tx");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
